hilo_muldiv_ctrl: RTL and testbench

//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO. Owns the architectural HI/LO pair.

---
 rtl/hilo_muldiv_ctrl_if.sv | 34 +++
 rtl/hilo_muldiv_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_ctrl_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply/divide sequencer.
//   master : execute stage (drives req_valid, req_op, req_a, req_b, flush)
//   slave  : hilo_muldiv_ctrl (drives req_ready, busy, done, dbz, hi, lo)
// Signals:
//   req_valid / req_ready : op handshake, transfer on both high at a rising edge
//   req_op                : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
//   req_a / req_b         : rs / rt operand values
//   flush                 : cancel the in-flight op; also blocks acceptance while idle
//   busy                  : an op is in flight (MFHI/MFLO must stall)
//   done / dbz            : completion pulse, with divide-by-zero qualifier
//   hi / lo               : architectural HI/LO registers
interface hilo_muldiv_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output req_valid, req_op, req_a, req_b, flush,
    input  req_ready, busy, done, dbz, hi, lo
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush,
    output req_ready, busy, done, dbz, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO that owns the HI/LO pair.
// One op is accepted at a time over the bus handshake. Multiplies commit after a fixed
// MUL_LATENCY; divides run a restoring divider (one quotient bit per cycle, 32 steps) and
// then spend one FIX cycle applying sign correction before committing.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : hilo_muldiv_ctrl_if.slave (request, flush, status, HI/LO)
module hilo_muldiv_ctrl #(
  parameter int unsigned MUL_LATENCY = 4  // accept edge to commit edge, legal 1..8
) (
  input logic               clk,
  input logic               reset,
  hilo_muldiv_ctrl_if.slave bus
);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  localparam logic [4:0] MulCntInit  = 5'(MUL_LATENCY - 1);
  localparam logic [4:0] DivLastStep = 5'd31;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  // opa_q: multiplicand, or dividend that shifts out as the quotient shifts in.
  // opb_q: multiplier or divisor magnitude.
  logic [31:0] opa_q, opb_q;
  logic [31:0] rem_q;
  logic        mul_signed_q;
  logic        dbz_q;
  logic        neg_quot_q, neg_rem_q;

  logic        idle;
  logic        accept;
  logic        div_signed;
  logic [32:0] rem_shift;
  logic        div_fits;
  logic [31:0] div_rem_next;
  logic [31:0] quot_fixed, rem_fixed;
  logic [63:0] mul_a_ext, mul_b_ext, product;

  assign idle   = (state_q == StIdle);
  // flush while idle blocks acceptance of every op, MTHI/MTLO included.
  assign accept = idle && bus.req_valid && !bus.flush;
  assign div_signed = (bus.req_op == OpDiv);

  // Datapath helpers
  always_comb begin
    rem_shift    = {rem_q, opa_q[31]};
    div_fits     = (rem_shift >= {1'b0, opb_q});
    div_rem_next = div_fits ? 32'(rem_shift - {1'b0, opb_q}) : rem_shift[31:0];
    quot_fixed   = neg_quot_q ? -opa_q : opa_q;
    rem_fixed    = neg_rem_q ? -rem_q : rem_q;
    // Low 64 bits of the product of the sign/zero-extended operands is the exact result.
    mul_a_ext    = {{32{mul_signed_q & opa_q[31]}}, opa_q};
    mul_b_ext    = {{32{mul_signed_q & opb_q[31]}}, opb_q};
    product      = mul_a_ext * mul_b_ext;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (bus.req_op)
            OpMult, OpMultu: state_d = StMul;
            OpDiv, OpDivu:   state_d = (bus.req_b == '0) ? StFix : StDiv;
            default:         state_d = StIdle;
          endcase
        end
      end
      StMul: if (cnt_q == '0) state_d = StIdle;
      StDiv: if (cnt_q == DivLastStep) state_d = StFix;
      StFix: state_d = StIdle;
    endcase
    if (bus.flush && !idle) begin
      state_d = StIdle;
    end
  end

  // FSM: outputs
  always_comb begin
    bus.req_ready = idle;
    bus.busy      = !idle;
    bus.done      = !bus.flush && (((state_q == StMul) && (cnt_q == '0)) || (state_q == StFix));
    bus.dbz       = !bus.flush && (state_q == StFix) && dbz_q;
    bus.hi        = hi_q;
    bus.lo        = lo_q;
  end

  // Operand, counter and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      rem_q        <= '0;
      mul_signed_q <= 1'b0;
      dbz_q        <= 1'b0;
      neg_quot_q   <= 1'b0;
      neg_rem_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            case (bus.req_op)
              OpMthi: hi_q <= bus.req_a;
              OpMtlo: lo_q <= bus.req_a;
              OpMult, OpMultu: begin
                opa_q        <= bus.req_a;
                opb_q        <= bus.req_b;
                mul_signed_q <= (bus.req_op == OpMult);
                cnt_q        <= MulCntInit;
              end
              OpDiv, OpDivu: begin
                opa_q      <= (div_signed && bus.req_a[31]) ? -bus.req_a : bus.req_a;
                opb_q      <= (div_signed && bus.req_b[31]) ? -bus.req_b : bus.req_b;
                rem_q      <= '0;
                cnt_q      <= '0;
                dbz_q      <= (bus.req_b == '0);
                neg_quot_q <= div_signed && (bus.req_a[31] ^ bus.req_b[31]);
                neg_rem_q  <= div_signed && bus.req_a[31];
              end
              default: ;
            endcase
          end
        end
        StMul: begin
          if (!bus.flush) begin
            if (cnt_q == '0) begin
              {hi_q, lo_q} <= product;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
        end
        StDiv: begin
          if (!bus.flush) begin
            rem_q <= div_rem_next;
            opa_q <= {opa_q[30:0], div_fits};
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StFix: begin
          if (!bus.flush && !dbz_q) begin
            lo_q <= quot_fixed;
            hi_q <= rem_fixed;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed cases followed by random ops, each
// checked against an arithmetic reference model of HI/LO, done timing and dbz.
module tb_hilo_muldiv_ctrl;
  localparam int unsigned MulLat = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl_if bus ();

  hilo_muldiv_ctrl #(.MUL_LATENCY(MulLat)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and follow it to completion. flush_at >= 0 raises flush in that cycle
  // after accept (cycle 0 is the one right after the accept edge).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at);
    logic [31:0] nhi, nlo;
    logic        exp_done, exp_dbz, dbz_seen, ended;
    int          exp_cyc, end_cyc, done_cnt, done_cyc;
    longint      sp, sq, sr;
    logic [63:0] up;

    nhi = m_hi; nlo = m_lo;
    exp_done = 1'b0; exp_dbz = 1'b0; exp_cyc = -1;
    case (op)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {nhi, nlo} = sp;
        exp_done = 1'b1; exp_cyc = MulLat - 1;
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        {nhi, nlo} = up;
        exp_done = 1'b1; exp_cyc = MulLat - 1;
      end
      3'd2, 3'd3: begin
        exp_done = 1'b1;
        if (b == 32'd0) begin
          exp_dbz = 1'b1; exp_cyc = 0;
        end else begin
          exp_cyc = 32;
          if (op == 3'd2) begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            nlo = sq[31:0]; nhi = sr[31:0];
          end else begin
            nlo = a / b; nhi = a % b;
          end
        end
      end
      3'd4: nhi = a;
      3'd5: nlo = a;
      default: ;
    endcase
    if (!(exp_done && flush_at >= 0 && flush_at < exp_cyc)) flush_at = -1;
    if (flush_at >= 0) begin
      exp_done = 1'b0; nhi = m_hi; nlo = m_lo; end_cyc = flush_at + 1;
    end else begin
      end_cyc = exp_done ? exp_cyc + 1 : 0;
    end

    @(negedge clk);
    chk("ready_before_req", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    @(negedge clk);
    // Scramble inputs after accept: the DUT must use its latched operands.
    bus.req_valid = 1'b0; bus.req_op = 3'($urandom); bus.req_a = $urandom; bus.req_b = $urandom;
    done_cnt = 0; done_cyc = -1; dbz_seen = 1'b0; ended = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (bus.done) begin
        done_cnt++; done_cyc = i; dbz_seen = bus.dbz;
        chk("ready_in_done", bus.req_ready, 0);
      end
      if (!bus.busy) begin
        chk("busy_drop_cycle", i, end_cyc);
        ended = 1'b1;
        break;
      end
      bus.flush = (i == flush_at);
      @(negedge clk);
    end
    bus.flush = 1'b0;
    chk("op_finished", ended, 1);
    chk("done_count", done_cnt, exp_done ? 1 : 0);
    if (exp_done) begin
      chk("done_cycle", done_cyc, exp_cyc);
      chk("dbz", dbz_seen, exp_dbz);
    end
    chk("hi", bus.hi, nhi);
    chk("lo", bus.lo, nlo);
    chk("ready_after", bus.req_ready, 1);
    m_hi = nhi; m_lo = nlo;
  endtask

  initial begin
    int dcount;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          rf;

    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_a = '0; bus.req_b = '0; bus.flush = 1'b0;
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    #1;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz", bus.dbz, 0);
    chk("rst_ready", bus.req_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    run_op(3'd3, 32'd100, 32'd7, -1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, -1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, -1);
    run_op(3'd4, 32'h11, 32'd0, -1);
    run_op(3'd5, 32'h22, 32'd0, -1);
    run_op(3'd2, 32'd5, 32'd0, -1);
    run_op(3'd6, 32'hDEAD_BEEF, 32'd1, -1);
    run_op(3'd3, 32'hFFFF_0000, 32'd3, 10);
    run_op(3'd1, 32'd3, 32'd4, -1);

    // flush while idle: MTHI must not be taken
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.req_a = 32'hABCD_0123; bus.flush = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    chk("idle_flush_hi", bus.hi, m_hi);
    chk("idle_flush_busy", bus.busy, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 0) rb = 32'($urandom_range(1, 1000));
      rf  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_op(rop, ra, rb, rf);
    end

    // Async reset mid-divide
    run_op(3'd4, 32'h5555_AAAA, 32'd0, -1);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_a = 32'd1000; bus.req_b = 32'd9;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_hi", bus.hi, 0);
    chk("mid_rst_lo", bus.lo, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    chk("post_rst_no_done", dcount, 0);
    chk("post_rst_hi", bus.hi, 0);
    chk("post_rst_lo", bus.lo, 0);
    run_op(3'd0, 32'h0001_0000, 32'h0001_0000, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
